operand_bypass_unit: RTL

OPERAND_BYPASS_UNIT -- requirements
Module: operand_bypass_unit

---
 rtl/operand_bypass_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/operand_bypass_unit.sv
// rtl/operand_bypass_unit.sv - operand forwarding mux with hazard detection and stall counting
module operand_bypass_unit #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 3,
  parameter int AW     = 5,
  parameter int CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [AW-1:0]          req_addr,
  input  logic [DATA_W-1:0]      rf_data,
  input  logic                   hold_in,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC-1:0]        src_ready,
  input  logic [NSRC*AW-1:0]     src_waddr,
  input  logic [NSRC*DATA_W-1:0] src_wdata,
  output logic [DATA_W-1:0]      operand,
  output logic                   operand_valid,
  output logic [NSRC:0]          fwd_sel,
  output logic                   hazard_stall,
  output logic [CNT_W-1:0]       stall_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    WAIT   = 2'd2
  } stateType;

  stateType          state;
  logic              winnerFound;
  logic              winnerReady;
  logic [DATA_W-1:0] winnerData;
  logic [NSRC:0]     nextSel;
  logic [DATA_W-1:0] nextData;
  logic              capture;
  logic              stallNow;

  // Pick the youngest matching source; scanning oldest-first lets lower indices overwrite.
  // Address 0 is hardwired zero and never matches a forwarding source.
  always_comb begin
    winnerFound = 1'b0;
    winnerReady = 1'b0;
    winnerData  = '0;
    nextSel     = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_valid[i] && (src_waddr[i*AW +: AW] == req_addr) && (req_addr != '0)) begin
        winnerFound = 1'b1;
        winnerReady = src_ready[i];
        winnerData  = src_wdata[i*DATA_W +: DATA_W];
        nextSel     = '0;
        nextSel[i]  = 1'b1;
      end
    end
    if (winnerFound) begin
      nextData = winnerData;
    end else begin
      nextSel       = '0;
      nextSel[NSRC] = 1'b1;
      nextData      = (req_addr == '0) ? '0 : rf_data;
    end
    // A non-ready youngest match stalls even if an older match is ready.
    stallNow = req_valid && winnerFound && !winnerReady;
    capture  = req_valid && !stallNow && !hold_in;
  end

  assign hazard_stall = stallNow;

  // Request FSM with registered operand, select and valid outputs; hold freezes everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      operand       <= '0;
      operand_valid <= 1'b0;
      fwd_sel       <= '0;
    end else if (!hold_in) begin
      case (state)
        IDLE, LOADED, WAIT: begin
          if (!req_valid) begin
            state         <= IDLE;
            operand_valid <= 1'b0;
          end else if (stallNow) begin
            state         <= WAIT;
            operand_valid <= 1'b0;
          end else if (capture) begin
            state         <= LOADED;
            operand_valid <= 1'b1;
            operand       <= nextData;
            fwd_sel       <= nextSel;
          end
        end
        default: begin
          state         <= IDLE;
          operand_valid <= 1'b0;
        end
      endcase
    end
  end

  // Count hazard cycles regardless of hold, saturating at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stallNow && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
